// File: rtl/sd_tx_ctrl_if.sv
// sd_tx_ctrl_if: upstream payload byte stream (valid/ready) feeding the SD write sequencer
interface sd_tx_ctrl_if;
    logic [7:0] wr_byte;
    logic       wr_valid;
    logic       wr_ready;
    modport master (output wr_byte, output wr_valid, input wr_ready);
    modport slave  (input wr_byte, input wr_valid, output wr_ready);
endinterface

// File: rtl/sd_tx_ctrl.sv
// sd_tx_ctrl: sequences SD command frames and write blocks into the command/data shifters (SD_CRC7_EN computes CRC7 internally)
module sd_tx_ctrl #(
    parameter int BLOCK_BYTES = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rising_edge_sclk_i,
    input  logic               cmd_start_i,
    input  logic [5:0]         cmd_index_i,
    input  logic [31:0]        cmd_arg_i,
    input  logic [6:0]         cmd_crc_i,
    input  logic               blk_start_i,
    sd_tx_ctrl_if.slave        wr_if,
    output logic               load_command_o,
    output logic               shift_command_o,
    output logic               load_data_o,
    output logic               shift_data_o,
    output logic [47:0]        command_o,
    output logic [7:0]         data_o,
    output logic               sclk_en_o,
    output logic               busy_o,
    output logic               cmd_done_o,
    output logic               blk_done_o
);
    localparam int IW = $clog2(BLOCK_BYTES + 4);
    localparam logic [IW-1:0] PAY_LAST = IW'(BLOCK_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES + 2);

    typedef enum logic [2:0] {IDLE, CMD_LOAD, CMD_SHIFT, DATA_FETCH, DATA_LOAD, DATA_SHIFT} state_t;

    state_t        state_q, state_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic [47:0]   command_q, command_d;
    logic [7:0]    data_q, data_d;
    logic          cmd_done_q, cmd_done_d;
    logic          blk_done_q, blk_done_d;
    logic [6:0]    crc7;
    logic          payload;

`ifdef SD_CRC7_EN
    logic unused_cmd_crc;

    function automatic logic [6:0] crc7_calc(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc7 = crc7_calc({2'b01, cmd_index_i, cmd_arg_i});
    assign unused_cmd_crc = ^cmd_crc_i;
`else
    assign crc7 = cmd_crc_i;
`endif

    // payload indices are 1..BLOCK_BYTES; 0 is the start token, the last two are CRC bytes
    assign payload         = (byte_idx_q != '0) && (byte_idx_q <= PAY_LAST);
    assign wr_if.wr_ready  = (state_q == DATA_FETCH) && payload;
    assign load_command_o  = state_q == CMD_LOAD;
    assign shift_command_o = state_q == CMD_SHIFT;
    assign load_data_o     = state_q == DATA_LOAD;
    assign shift_data_o    = state_q == DATA_SHIFT;
    assign sclk_en_o       = shift_command_o || shift_data_o;
    assign busy_o          = state_q != IDLE;
    assign command_o       = command_q;
    assign data_o          = data_q;
    assign cmd_done_o      = cmd_done_q;
    assign blk_done_o      = blk_done_q;

    // next-state: SCLK edges only count in the shift states, fetch stalls until upstream has a byte
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        command_d  = command_q;
        data_d     = data_q;
        cmd_done_d = 1'b0;
        blk_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start_i) begin
                    command_d = {2'b01, cmd_index_i, cmd_arg_i, crc7, 1'b1};
                    state_d   = CMD_LOAD;
                end else if (blk_start_i) begin
                    data_d     = 8'hFE;
                    byte_idx_d = '0;
                    state_d    = DATA_LOAD;
                end
            end
            CMD_LOAD: begin
                bit_cnt_d = '0;
                state_d   = CMD_SHIFT;
            end
            CMD_SHIFT: begin
                if (rising_edge_sclk_i) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd47) begin
                        state_d    = IDLE;
                        cmd_done_d = 1'b1;
                    end
                end
            end
            DATA_LOAD: begin
                bit_cnt_d = '0;
                state_d   = DATA_SHIFT;
            end
            DATA_SHIFT: begin
                if (rising_edge_sclk_i) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = (byte_idx_q == LAST_IDX) ? IDLE : DATA_FETCH;
                        blk_done_d = byte_idx_q == LAST_IDX;
                    end
                end
            end
            DATA_FETCH: begin
                if (!payload) begin
                    data_d  = 8'hFF;
                    state_d = DATA_LOAD;
                end else if (wr_if.wr_valid) begin
                    data_d  = wr_if.wr_byte;
                    state_d = DATA_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any transfer without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            command_q  <= '0;
            data_q     <= '0;
            cmd_done_q <= 1'b0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            command_q  <= command_d;
            data_q     <= data_d;
            cmd_done_q <= cmd_done_d;
            blk_done_q <= blk_done_d;
        end
    end
endmodule

// File: tb/tb_sd_tx_ctrl.sv
// tb_sd_tx_ctrl: directed checks of command framing, block streaming, stalls and reset abort
module tb_sd_tx_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rising_edge_sclk_i = 1'b0;
    logic        cmd_start_i = 1'b0;
    logic [5:0]  cmd_index_i = '0;
    logic [31:0] cmd_arg_i = '0;
    logic [6:0]  cmd_crc_i = '0;
    logic        blk_start_i = 1'b0;
    logic        load_command_o, shift_command_o, load_data_o, shift_data_o;
    logic [47:0] command_o;
    logic [7:0]  data_o;
    logic        sclk_en_o, busy_o, cmd_done_o, blk_done_o;
    logic [79:0] all_outs;

    sd_tx_ctrl_if wr_if();

    sd_tx_ctrl #(.BLOCK_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .rising_edge_sclk_i(rising_edge_sclk_i),
        .cmd_start_i(cmd_start_i), .cmd_index_i(cmd_index_i),
        .cmd_arg_i(cmd_arg_i), .cmd_crc_i(cmd_crc_i),
        .blk_start_i(blk_start_i),
        .wr_if(wr_if),
        .load_command_o(load_command_o), .shift_command_o(shift_command_o),
        .load_data_o(load_data_o), .shift_data_o(shift_data_o),
        .command_o(command_o), .data_o(data_o),
        .sclk_en_o(sclk_en_o), .busy_o(busy_o),
        .cmd_done_o(cmd_done_o), .blk_done_o(blk_done_o)
    );

    assign all_outs = {15'd0, load_command_o, shift_command_o, load_data_o, shift_data_o,
                       command_o, data_o, sclk_en_o, busy_o, cmd_done_o, blk_done_o, wr_if.wr_ready};

`ifdef SD_CRC7_EN
    localparam logic [47:0] CMD8_EXP = 48'h48000001AA87;
`else
    localparam logic [47:0] CMD8_EXP = 48'h48000001AA01;
`endif

    int n_vec = 0, n_err = 0;
    int n_lc = 0, cmd_edges = 0, blk_edges = 0, hs_cnt = 0, n_ov = 0;
    int n_cmd_done = 0, n_blk_done = 0, cmd_edges_at_done = 0, blk_edges_at_done = 0;
    int hs_base = 0;
    logic busy_at_done = 1'b1;
    logic [7:0] seq[$];
    logic [7:0] pay [4];
    bit ph = 1'b0;

    initial forever #5 clk = ~clk;

    // free-running SCLK edge pulses every other clk, deliberately ungated
    initial forever begin
        @(posedge clk);
        #2;
        ph = !ph;
        rising_edge_sclk_i = ph;
    end

    // upstream byte source presents the next payload byte after each handshake
    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_byte = 8'h00;
        forever begin
            int idx;
            @(posedge clk);
            #2;
            idx = hs_cnt - hs_base;
            wr_if.wr_byte = (idx >= 0 && idx < 4) ? pay[idx] : 8'h00;
        end
    end

    // observe on the falling edge what the next rising edge will consume
    always @(negedge clk) begin
        if (load_command_o) n_lc++;
        if (load_data_o) seq.push_back(data_o);
        if (rising_edge_sclk_i && shift_command_o) cmd_edges++;
        if (rising_edge_sclk_i && shift_data_o) blk_edges++;
        if (wr_if.wr_valid && wr_if.wr_ready) hs_cnt++;
        if ((load_command_o && shift_command_o) || (load_data_o && shift_data_o) ||
            (sclk_en_o && !(shift_command_o || shift_data_o))) n_ov++;
        if (cmd_done_o) begin
            n_cmd_done++;
            cmd_edges_at_done = cmd_edges;
            busy_at_done = busy_o;
        end
        if (blk_done_o) begin
            n_blk_done++;
            blk_edges_at_done = blk_edges;
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input string t, input logic [5:0] idx, input logic [31:0] arg,
                            input logic [6:0] crc, input logic [47:0] exp);
        int b_lc, b_ce, b_cd;
        b_lc = n_lc;
        b_ce = cmd_edges;
        b_cd = n_cmd_done;
        cmd_index_i = idx;
        cmd_arg_i = arg;
        cmd_crc_i = crc;
        cmd_start_i = 1'b1;
        step();
        cmd_start_i = 1'b0;
        check({t, "_load"}, 80'(load_command_o), 80'd1);
        check({t, "_frame"}, 80'(command_o), 80'(exp));
        step();
        check({t, "_shift"}, 80'({load_command_o, shift_command_o, sclk_en_o}), 80'b011);
        for (int i = 0; i < 400 && n_cmd_done == b_cd; i++) step();
        check({t, "_done_once"}, 80'(n_cmd_done - b_cd), 80'd1);
        check({t, "_edges"}, 80'(cmd_edges_at_done - b_ce), 80'd48);
        check({t, "_busy_at_done"}, 80'(busy_at_done), 80'd0);
        check({t, "_load_pulses"}, 80'(n_lc - b_lc), 80'd1);
    endtask

    task automatic run_block(input string t, input bit stall, input logic [7:0] exp [7]);
        int b_seq, b_be, b_hs, b_bd, bad;
        b_seq = seq.size();
        b_be = blk_edges;
        b_hs = hs_cnt;
        b_bd = n_blk_done;
        bad = 0;
        hs_base = hs_cnt;
        wr_if.wr_valid = 1'b1;
        blk_start_i = 1'b1;
        step();
        blk_start_i = 1'b0;
        check({t, "_load_fe"}, 80'({load_data_o, data_o}), 80'({1'b1, 8'hFE}));
        if (stall) begin
            for (int i = 0; i < 300 && hs_cnt - b_hs < 1; i++) step();
            wr_if.wr_valid = 1'b0;
            for (int i = 0; i < 300 && !wr_if.wr_ready; i++) step();
            for (int i = 0; i < 20; i++) begin
                step();
                if (sclk_en_o || shift_data_o || !wr_if.wr_ready) bad++;
            end
            check({t, "_stall_gate"}, 80'(bad), 80'd0);
            wr_if.wr_valid = 1'b1;
        end
        for (int i = 0; i < 1000 && n_blk_done == b_bd; i++) step();
        wr_if.wr_valid = 1'b0;
        repeat (20) step();
        check({t, "_blk_done_once"}, 80'(n_blk_done - b_bd), 80'd1);
        check({t, "_edges"}, 80'(blk_edges_at_done - b_be), 80'd56);
        check({t, "_handshakes"}, 80'(hs_cnt - b_hs), 80'd4);
        check({t, "_loads"}, 80'(seq.size() - b_seq), 80'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("%s_byte%0d", t, i), 80'(seq[b_seq + i]), 80'(exp[i]));
        check({t, "_idle"}, 80'(busy_o), 80'd0);
    endtask

    initial begin
        logic [7:0] e3 [7];
        logic [7:0] e4 [7];
        int b_cd, b_bd, b_seq, b_be;
        e3 = '{8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF};
        e4 = '{8'hFE, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'hFF, 8'hFF};
        repeat (3) step();
        check("reset_outs", all_outs, 80'd0);
        rst = 1'b0;
        step();

        send_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 48'h400000000095);
        step();
        check("cmd0_done_pulse_width", 80'(cmd_done_o), 80'd0);
        send_cmd("cmd8", 6'd8, 32'h000001AA, 7'h00, CMD8_EXP);

        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_block("blk", 1'b0, e3);

        pay = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        run_block("stall", 1'b1, e4);

        b_cd = n_cmd_done;
        b_bd = n_blk_done;
        b_seq = seq.size();
        cmd_index_i = 6'd0;
        cmd_arg_i = 32'h0;
        cmd_crc_i = 7'h4A;
        cmd_start_i = 1'b1;
        blk_start_i = 1'b1;
        step();
        cmd_start_i = 1'b0;
        blk_start_i = 1'b0;
        check("both_cmd_wins", 80'({load_command_o, load_data_o}), 80'b10);
        repeat (5) step();
        blk_start_i = 1'b1;
        step();
        blk_start_i = 1'b0;
        check("busy_start_ignored", 80'(shift_command_o), 80'd1);
        for (int i = 0; i < 400 && n_cmd_done == b_cd; i++) step();
        repeat (30) step();
        check("both_cmd_done", 80'(n_cmd_done - b_cd), 80'd1);
        check("both_no_block", 80'({n_blk_done - b_bd, seq.size() - b_seq}), 80'd0);
        check("both_idle", 80'(busy_o), 80'd0);

        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        hs_base = hs_cnt;
        b_be = blk_edges;
        b_bd = n_blk_done;
        wr_if.wr_valid = 1'b1;
        blk_start_i = 1'b1;
        step();
        blk_start_i = 1'b0;
        for (int i = 0; i < 500 && blk_edges - b_be < 29; i++) step();
        check("abort_reached", 80'(blk_edges - b_be), 80'd29);
        wr_if.wr_valid = 1'b0;
        rst = 1'b1;
        step();
        check("abort_outs", all_outs, 80'd0);
        rst = 1'b0;
        repeat (100) step();
        check("abort_no_blk_done", 80'(n_blk_done - b_bd), 80'd0);
        check("abort_idle", 80'(busy_o), 80'd0);
        send_cmd("post_rst", 6'd0, 32'h0, 7'h4A, 48'h400000000095);

        check("strobe_overlap", 80'(n_ov), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sd_tx_ctrl.md
Name: sd_tx_ctrl

Overview:
Sequencer for the SD write-path parallel-to-serial datapath: the 48-bit command shifter and the 8-bit data shifter.
- Builds 48-bit SD command frames and drives load/shift strobes for command transmission.
- Streams a full write block: start token, payload, 2 CRC bytes.
- Pulls payload bytes from an upstream byte source (e.g. the USB bulk FIFO) over a valid/ready handshake.
- Gates the SCLK generator so no SCLK edge is ever issued while a shifter is not ready.

Parameters:
BLOCK_BYTES, 512, payload bytes per write block (range 1..4096)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rising_edge_sclk  in  1  one-clk pulse per SCLK rising edge from the SCLK generator
cmd_start  in  1  request a command transmit (sampled in IDLE only)
cmd_index  in  6  SD command index
cmd_arg  in  32  command argument
cmd_crc  in  7  CRC7 field, used only when SD_CRC7_EN is undefined
blk_start  in  1  request a data-block transmit (sampled in IDLE only)
wr_byte  in  8  payload byte from upstream
wr_valid  in  1  wr_byte valid
wr_ready  out  1  controller accepts wr_byte this cycle
load_command  out  1  parallel-load strobe, command shifter
shift_command  out  1  command shift window
load_data  out  1  parallel-load strobe, data shifter
shift_data  out  1  data shift window
command  out  48  frame presented to command shifter
data  out  8  byte presented to data shifter
sclk_en  out  1  permits the SCLK generator to run
busy  out  1  state != IDLE
cmd_done  out  1  one-cycle pulse, command fully shifted
blk_done  out  1  one-cycle pulse, block fully shifted

Behaviour:
- Reset: state IDLE; all outputs 0, including command and data; bit and byte counters 0. A reset mid-operation aborts immediately, and no done pulse is issued.
- States: IDLE, CMD_LOAD, CMD_SHIFT, DATA_FETCH, DATA_LOAD, DATA_SHIFT. All outputs are registered or decoded from state.
- IDLE:
  - cmd_start=1: command <= {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, then go to CMD_LOAD.
  - else if blk_start=1: data <= 8'hFE, byte_idx <= 0, then go to DATA_LOAD.
  - Both asserted in the same cycle: command wins and blk_start is dropped.
  - Starts are ignored while busy.
- CMD_LOAD: load_command=1 for exactly one cycle; bit_cnt <= 0; go to CMD_SHIFT.
- CMD_SHIFT:
  - Outputs: shift_command=1, sclk_en=1.
  - Each rising_edge_sclk increments bit_cnt.
  - On the edge with bit_cnt==47: next cycle state is IDLE and cmd_done=1 for one cycle.
- DATA_LOAD: load_data=1 for one cycle; bit_cnt <= 0; go to DATA_SHIFT.
- DATA_SHIFT:
  - Outputs: shift_data=1, sclk_en=1.
  - On the 8th edge, byte_idx increments.
  - If the finished byte was byte BLOCK_BYTES+2 (the 2nd CRC byte): go to IDLE and pulse blk_done.
  - Otherwise go to DATA_FETCH.
- DATA_FETCH:
  - For byte_idx 1..BLOCK_BYTES: wr_ready=1. On wr_valid&&wr_ready, data <= wr_byte and go to DATA_LOAD. With wr_valid=0, wait indefinitely: SCLK stays stopped and MOSI stays idle-high.
  - For byte_idx BLOCK_BYTES+1 or +2: data <= 8'hFF (dummy CRC16), no handshake, go to DATA_LOAD.
- Strobe and clock gating:
  - shift_* and sclk_en are 0 in all LOAD/FETCH/IDLE states.
  - load_* and shift_* are never asserted in the same cycle.
  - rising_edge_sclk outside the SHIFT states is ignored and does not count.
- Latency:
  - cmd_start at cycle N gives load_command at N+1 and shift_command from N+2.
  - Inter-byte gap is at least 2 clk (FETCH + LOAD) with no SCLK edges in the gap.
- wr_ready is asserted only in DATA_FETCH on payload indices. Exactly BLOCK_BYTES handshakes occur per block.

Optional Feature:
SD_CRC7_EN
- Defined: crc7 is computed from {2'b01, cmd_index, cmd_arg} (40 bits, polynomial x^7+x^3+1, init 0, MSB first). cmd_crc is ignored. The result is registered together with command at the IDLE capture; latency is unchanged.
- Undefined: crc7 = cmd_crc.

Test Plan:
1. With SD_CRC7_EN, CMD0 (idx 0, arg 0):
   - command=48'h400000000095.
   - load_command is a 1-cycle pulse.
   - Exactly 48 counted edges, then cmd_done; busy falls the same cycle.
2. With SD_CRC7_EN, CMD8 arg 32'h000001AA: command=48'h48000001AA87. Without the macro, cmd_crc=7'h00 gives command=48'h48000001AA01.
3. blk_start, BLOCK_BYTES=4, bytes 11,22,33,44 always valid:
   - data sequence FE,11,22,33,44,FF,FF.
   - 7 load_data pulses and 56 counted edges.
   - blk_done once; exactly 4 handshakes.
4. Payload stall: hold wr_valid=0 for 20 clk at byte 2.
   - sclk_en=0 and shift_data=0 throughout the stall.
   - Edges injected during the stall are not counted.
   - The stream resumes correctly.
5. cmd_start and blk_start asserted together in IDLE: the command is sent and the block request is dropped. A blk_start pulsed during CMD_SHIFT has no effect.
6. rst asserted mid-block (byte 3, bit 5): next cycle all outputs are 0 and state is IDLE, with no blk_done. A new cmd_start then completes normally.
